// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared definitions for the run sequencer slice.
//   - seqState_t : FSM state encodings (also driven out on the state port)
//   - DW         : data word width of the default build (CORE_COUNT*REG_WIDTH)
//   - dataWidth  : data word width for an arbitrary core count / register width
//   - cntWidth   : counter width able to hold 0..limit-1
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_EXEC   = 3'd2,
    ST_DUMP   = 3'd3,
    ST_FINISH = 3'd4,
    ST_TOUT   = 3'd5
  } seqState_t;

  localparam int DEF_CORE_COUNT = 1;
  localparam int DEF_REG_WIDTH  = 12;
  localparam int DW             = DEF_CORE_COUNT * DEF_REG_WIDTH;

  function automatic int dataWidth(input int coreCount, input int regWidth);
    return coreCount * regWidth;
  endfunction

  function automatic int cntWidth(input int limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/run_seq_if.sv
// run_seq_if: every non-clock signal of the run sequencer.
//   master : the sequencer (drives RAM ports, proc_startN, result stream, status)
//   slave  : the surroundings (host loader, processor, RAMs, result sink)
//
// Result stream handshake (dump_valid / dump_ready): a word transfers on a
// rising clock edge where both are high. Once dump_valid is high it stays high,
// with dump_data and dump_addr unchanged, until a transfer occurs. dump_valid
// never depends combinationally on dump_ready.
interface run_seq_if #(
  parameter int DW            = run_seq_pkg::DW,
  parameter int DAW           = 12,
  parameter int IAW           = 8,
  parameter int INS_WIDTH     = 8,
  parameter int RUN_CNT_WIDTH = 8
);
  // host side
  logic                     startN;
  logic                     load_req;
  logic                     ld_valid;
  logic                     ld_sel;
  logic [DAW-1:0]           ld_addr;
  logic [DW-1:0]            ld_data;
  logic                     ld_done;
  // processor side
  logic                     proc_startN;
  logic                     proc_done;
  logic [DAW-1:0]           proc_dm_addr;
  logic [DW-1:0]            proc_dm_data;
  logic                     proc_dm_wr_en;
  logic [IAW-1:0]           proc_im_addr;
  // data RAM
  logic [DAW-1:0]           dm_addr;
  logic [DW-1:0]            dm_data_in;
  logic                     dm_wr_en;
  logic [DW-1:0]            dm_data_out;
  // instruction RAM
  logic [IAW-1:0]           im_addr;
  logic [INS_WIDTH-1:0]     im_data_in;
  logic                     im_wr_en;
  // result stream
  logic                     dump_valid;
  logic [DW-1:0]            dump_data;
  logic [DAW-1:0]           dump_addr;
  logic                     dump_ready;
  // status
  logic [2:0]               state;
  logic                     busy;
  logic                     timeout;
  logic [RUN_CNT_WIDTH-1:0] run_count;

  modport master (
    input  startN, load_req, ld_valid, ld_sel, ld_addr, ld_data, ld_done,
           proc_done, proc_dm_addr, proc_dm_data, proc_dm_wr_en, proc_im_addr,
           dm_data_out, dump_ready,
    output proc_startN, dm_addr, dm_data_in, dm_wr_en, im_addr, im_data_in,
           im_wr_en, dump_valid, dump_data, dump_addr, state, busy, timeout,
           run_count
  );

  modport slave (
    output startN, load_req, ld_valid, ld_sel, ld_addr, ld_data, ld_done,
           proc_done, proc_dm_addr, proc_dm_data, proc_dm_wr_en, proc_im_addr,
           dm_data_out, dump_ready,
    input  proc_startN, dm_addr, dm_data_in, dm_wr_en, im_addr, im_data_in,
           im_wr_en, dump_valid, dump_data, dump_addr, state, busy, timeout,
           run_count
  );
endinterface

// File: rtl/run_seq_watchdog.sv
// run_seq_watchdog: EXEC watchdog counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the counter (takes priority over enable)
//   enable   : count one cycle
//   expired  : counter has reached LIMIT-1 while enabled; never set when LIMIT=0
module run_seq_watchdog import run_seq_pkg::*; #(
  parameter  int LIMIT = 65535,
  localparam int CW    = cntWidth(LIMIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) count <= '0;
    else if (enable)  count <= count + CW'(1);
  end

  generate
    if (LIMIT == 0) begin : gDisabled
      assign expired = 1'b0;
    end else begin : gEnabled
      assign expired = enable && (count == CW'(LIMIT - 1));
    end
  endgenerate

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: run controller for the multi-core processor.
// Sequences LOAD -> EXEC -> DUMP -> FINISH, muxes both RAM ports by state,
// watches EXEC with a watchdog and counts EXEC entries.
//   clk, rst : clock, synchronous active-high reset
//   bus      : run_seq_if.master (host, processor, RAM, result stream, status)
module run_sequencer import run_seq_pkg::*; #(
  parameter int CORE_COUNT          = 1,
  parameter int REG_WIDTH           = 12,
  parameter int INS_WIDTH           = 8,
  parameter int DATA_MEM_ADDR_WIDTH = 12,
  parameter int INS_MEM_ADDR_WIDTH  = 8,
  parameter int DUMP_BASE           = 0,
  parameter int DUMP_DEPTH          = 16,
  parameter int TIMEOUT_CYCLES      = 65535,
  parameter int RUN_CNT_WIDTH       = 8
) (
  input logic       clk,
  input logic       rst,
  run_seq_if.master bus
);

  localparam int DW  = dataWidth(CORE_COUNT, REG_WIDTH);
  localparam int DAW = DATA_MEM_ADDR_WIDTH;
  localparam int IAW = INS_MEM_ADDR_WIDTH;

  localparam logic [DAW-1:0] BASE_ADDR = DAW'(DUMP_BASE);
  localparam logic [DAW-1:0] LAST_ADDR = DAW'(DUMP_BASE + DUMP_DEPTH - 1);

  seqState_t              stateQ, stateD;
  logic [DAW-1:0]         rdPtr;
  logic                   dumpValidQ;
  logic [RUN_CNT_WIDTH-1:0] runCountQ;
  logic                   wdExpired;
  logic                   execEntry;
  logic                   dumpAccept;

  assign dumpAccept = dumpValidQ & bus.dump_ready;

  // Next-state logic
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE, ST_FINISH: begin
        if (bus.load_req)     stateD = ST_LOAD;
        else if (!bus.startN) stateD = ST_EXEC;
      end
      ST_LOAD: if (bus.ld_done) stateD = ST_IDLE;
      ST_EXEC: begin
        // done beats a watchdog expiry in the same cycle
        if (bus.proc_done)   stateD = (DUMP_DEPTH == 0) ? ST_FINISH : ST_DUMP;
        else if (wdExpired)  stateD = ST_TOUT;
      end
      ST_DUMP: if (dumpAccept && (rdPtr == LAST_ADDR)) stateD = ST_FINISH;
      ST_TOUT: stateD = ST_TOUT;
      default: stateD = ST_IDLE;
    endcase
  end

  assign execEntry = !rst && ((stateQ == ST_IDLE) || (stateQ == ST_FINISH)) &&
                     (stateD == ST_EXEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ     <= ST_IDLE;
      dumpValidQ <= 1'b0;
      rdPtr      <= BASE_ADDR;
      runCountQ  <= '0;
    end else begin
      stateQ <= stateD;
      // valid only from the second DUMP cycle on, when the first read has returned
      dumpValidQ <= (stateQ == ST_DUMP) && (stateD == ST_DUMP);
      if (stateQ != ST_DUMP) rdPtr <= BASE_ADDR;
      else if (dumpAccept)   rdPtr <= rdPtr + DAW'(1);
      if (execEntry) runCountQ <= runCountQ + RUN_CNT_WIDTH'(1);
    end
  end

  run_seq_watchdog #(.LIMIT(TIMEOUT_CYCLES)) uWatchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (execEntry),
    .enable  (stateQ == ST_EXEC),
    .expired (wdExpired)
  );

  // RAM port mux
  always_comb begin
    bus.dm_addr    = '0;
    bus.dm_data_in = '0;
    bus.dm_wr_en   = 1'b0;
    bus.im_addr    = '0;
    bus.im_data_in = '0;
    bus.im_wr_en   = 1'b0;
    case (stateQ)
      ST_LOAD: begin
        bus.dm_addr    = bus.ld_addr;
        bus.dm_data_in = DW'(bus.ld_data);
        bus.dm_wr_en   = bus.ld_valid & bus.ld_sel;
        bus.im_addr    = bus.ld_addr[IAW-1:0];
        bus.im_data_in = bus.ld_data[INS_WIDTH-1:0];
        bus.im_wr_en   = bus.ld_valid & ~bus.ld_sel;
      end
      ST_EXEC: begin
        bus.dm_addr    = bus.proc_dm_addr;
        bus.dm_data_in = bus.proc_dm_data;
        bus.dm_wr_en   = bus.proc_dm_wr_en;
        bus.im_addr    = bus.proc_im_addr;
      end
      // Read ahead on acceptance so the next word arrives right behind it;
      // on a stall the same address is re-read, keeping dump_data stable.
      ST_DUMP: bus.dm_addr = dumpAccept ? (rdPtr + DAW'(1)) : rdPtr;
      default: ;
    endcase
  end

  assign bus.proc_startN = ~execEntry;
  assign bus.dump_valid  = dumpValidQ;
  assign bus.dump_data   = bus.dm_data_out;
  assign bus.dump_addr   = rdPtr;
  assign bus.state       = stateQ;
  assign bus.busy        = (stateQ == ST_LOAD) || (stateQ == ST_EXEC) ||
                           (stateQ == ST_DUMP);
  assign bus.timeout     = (stateQ == ST_TOUT);
  assign bus.run_count   = runCountQ;

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

  localparam int DW    = 12;
  localparam int DAW   = 12;
  localparam int IAW   = 8;
  localparam int IW    = 8;
  localparam int RCW   = 8;
  localparam int BASE  = 8;
  localparam int DEPTH = 4;
  localparam int TMO   = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  run_seq_if #(.DW(DW), .DAW(DAW), .IAW(IAW), .INS_WIDTH(IW), .RUN_CNT_WIDTH(RCW)) bus ();

  run_sequencer #(
    .CORE_COUNT(1), .REG_WIDTH(12), .INS_WIDTH(IW),
    .DATA_MEM_ADDR_WIDTH(DAW), .INS_MEM_ADDR_WIDTH(IAW),
    .DUMP_BASE(BASE), .DUMP_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .RUN_CNT_WIDTH(RCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAMs around the DUT (1-cycle read latency on the data RAM)
  logic [DW-1:0] data_ram [0:(1<<DAW)-1];
  logic [IW-1:0] ins_ram  [0:(1<<IAW)-1];
  always @(posedge clk) begin
    if (bus.dm_wr_en) data_ram[bus.dm_addr] <= bus.dm_data_in;
    if (bus.im_wr_en) ins_ram[bus.im_addr]  <= bus.im_data_in;
    bus.dm_data_out <= data_ram[bus.dm_addr];
  end

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0]  mem_model [0:(1<<DAW)-1];
  logic [IW-1:0]  ins_model [0:(1<<IAW)-1];
  logic [DW-1:0]  exp_q[$];
  logic [DAW-1:0] exp_addr_q[$];
  int exp_runs = 0;
  int err_cnt  = 0;
  int chk_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.startN        = 1'b1;
    bus.load_req      = 1'b0;
    bus.ld_valid      = 1'b0;
    bus.ld_sel        = 1'b0;
    bus.ld_addr       = '0;
    bus.ld_data       = '0;
    bus.ld_done       = 1'b0;
    bus.proc_done     = 1'b0;
    bus.proc_dm_addr  = '0;
    bus.proc_dm_data  = '0;
    bus.proc_dm_wr_en = 1'b0;
    bus.proc_im_addr  = '0;
    bus.dump_ready    = 1'b0;
  endtask

  task automatic enter_load(input logic with_start, input int from_state);
    @(negedge clk);
    drive_idle();
    bus.load_req = 1'b1;
    bus.startN   = !with_start;
    #1;
    check("ldreq_state", bus.state, from_state);
    check("ldreq_pstartN", bus.proc_startN, 1);
  endtask

  task automatic ld_write(input logic sel, input logic [DAW-1:0] addr,
                          input logic [DW-1:0] data, input logic done);
    @(negedge clk);
    bus.load_req = 1'b0;
    bus.startN   = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_sel   = sel;
    bus.ld_addr  = addr;
    bus.ld_data  = data;
    bus.ld_done  = done;
    #1;
    check("ld_state", bus.state, 1);
    check("ld_busy", bus.busy, 1);
    check("ld_im_we", bus.im_wr_en, !sel);
    check("ld_dm_we", bus.dm_wr_en, sel);
    if (sel) begin
      check("ld_dm_addr", bus.dm_addr, addr);
      check("ld_dm_data", bus.dm_data_in, data);
      mem_model[addr] = data;
    end else begin
      check("ld_im_addr", bus.im_addr, addr[IAW-1:0]);
      check("ld_im_data", bus.im_data_in, data[IW-1:0]);
      ins_model[addr[IAW-1:0]] = data[IW-1:0];
    end
  endtask

  // cycle after ld_done: back in IDLE and a stray write strobe is ignored
  task automatic end_load();
    @(negedge clk);
    bus.ld_done  = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_sel   = 1'($urandom_range(0, 1));
    bus.ld_addr  = DAW'($urandom_range(0, 15));
    #1;
    check("postld_state", bus.state, 0);
    check("postld_im_we", bus.im_wr_en, 0);
    check("postld_dm_we", bus.dm_wr_en, 0);
  endtask

  // Start a run, spend n cycles in EXEC without done, raise done on cycle n+1.
  task automatic run_exec(input int n, input int from_state, input logic allow_wr);
    @(negedge clk);
    drive_idle();
    bus.startN = 1'b0;
    #1;
    check("ex_pstartN_low", bus.proc_startN, 0);
    check("ex_from_state", bus.state, from_state);
    exp_runs = (exp_runs + 1) % (1 << RCW);
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      bus.startN        = 1'b1;
      bus.proc_dm_addr  = DAW'($urandom_range(0, 15));
      bus.proc_dm_data  = DW'($urandom);
      bus.proc_dm_wr_en = allow_wr & 1'($urandom_range(0, 1));
      bus.proc_im_addr  = IAW'($urandom);
      bus.proc_done     = (i == n);
      #1;
      check("ex_state", bus.state, 2);
      check("ex_pstartN_high", bus.proc_startN, 1);
      check("ex_dm_addr", bus.dm_addr, bus.proc_dm_addr);
      check("ex_dm_data", bus.dm_data_in, bus.proc_dm_data);
      check("ex_dm_we", bus.dm_wr_en, bus.proc_dm_wr_en);
      check("ex_im_addr", bus.im_addr, bus.proc_im_addr);
      check("ex_im_we", bus.im_wr_en, 0);
      if (i == 0) check("ex_run_count", bus.run_count, exp_runs);
      if (bus.proc_dm_wr_en) mem_model[bus.proc_dm_addr] = bus.proc_dm_data;
    end
    @(negedge clk);
    drive_idle();
    #1;
    check("dump_entry_state", bus.state, 3);
    check("dump_entry_valid", bus.dump_valid, 0);
    check("dump_entry_timeout", bus.timeout, 0);
  endtask

  // mode 0: ready high, 1: ready toggling, 2: random ready
  task automatic run_dump(input int mode);
    int cycles;
    logic stalled;
    logic [DW-1:0]  prev_data;
    logic [DAW-1:0] prev_addr;
    cycles    = 0;
    stalled   = 1'b0;
    prev_data = '0;
    prev_addr = '0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      exp_addr_q.push_back(DAW'(BASE + i));
      exp_q.push_back(mem_model[DAW'(BASE + i)]);
    end
    while (exp_q.size() > 0 && cycles < 60) begin
      @(negedge clk);
      if (mode == 0)      bus.dump_ready = 1'b1;
      else if (mode == 1) bus.dump_ready = (cycles % 2 == 0);
      else                bus.dump_ready = 1'($urandom_range(0, 1));
      #1;
      cycles++;
      check("dmp_state", bus.state, 3);
      check("dmp_valid", bus.dump_valid, 1);
      if (bus.dump_valid) begin
        if (stalled) begin
          check("dmp_hold_data", bus.dump_data, prev_data);
          check("dmp_hold_addr", bus.dump_addr, prev_addr);
        end
        if (bus.dump_ready) begin
          check("dmp_data", bus.dump_data, exp_q.pop_front());
          check("dmp_addr", bus.dump_addr, exp_addr_q.pop_front());
          stalled = 1'b0;
        end else begin
          stalled   = 1'b1;
          prev_data = bus.dump_data;
          prev_addr = bus.dump_addr;
        end
      end
    end
    check("dmp_remaining", exp_q.size(), 0);
    if (mode == 0) check("dmp_rate", cycles, DEPTH);
    @(negedge clk);
    drive_idle();
    #1;
    check("fin_state", bus.state, 4);
    check("fin_valid", bus.dump_valid, 0);
    check("fin_busy", bus.busy, 0);
  endtask

  task automatic run_timeout();
    int n_exec;
    n_exec = 0;
    @(negedge clk);
    drive_idle();
    bus.startN = 1'b0;
    #1;
    check("to_pstartN_low", bus.proc_startN, 0);
    exp_runs = (exp_runs + 1) % (1 << RCW);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      bus.startN = 1'b1;
      #1;
      if (bus.state != 3'd2) break;
      n_exec++;
    end
    check("to_exec_cycles", n_exec, TMO);
    check("to_state", bus.state, 5);
    check("to_timeout", bus.timeout, 1);
    check("to_busy", bus.busy, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.startN        = 1'b0;
      bus.load_req      = (k == 1);
      bus.proc_dm_wr_en = 1'b1;
      bus.ld_valid      = 1'b1;
      #1;
      check("to_sticky_state", bus.state, 5);
      check("to_sticky_pstartN", bus.proc_startN, 1);
      check("to_dm_we", bus.dm_wr_en, 0);
      check("to_im_we", bus.im_wr_en, 0);
      check("to_run_count", bus.run_count, exp_runs);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    drive_idle();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_state", bus.state, 0);
    check("rst_valid", bus.dump_valid, 0);
    check("rst_run_count", bus.run_count, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_pstartN", bus.proc_startN, 1);
    check("rst_dm_addr", bus.dm_addr, 0);
    check("rst_dm_we", bus.dm_wr_en, 0);
    check("rst_im_we", bus.im_wr_en, 0);
    check("rst_dump_addr", bus.dump_addr, BASE);

    // load strobe outside LOAD is ignored
    @(negedge clk);
    bus.ld_valid = 1'b1;
    bus.ld_sel   = 1'b1;
    bus.ld_addr  = DAW'(3);
    #1;
    check("idle_dm_we", bus.dm_wr_en, 0);
    check("idle_im_we", bus.im_wr_en, 0);

    // fixed load
    enter_load(1'b0, 0);
    ld_write(1'b0, DAW'(0), DW'(12'h011), 1'b0);
    ld_write(1'b0, DAW'(1), DW'(12'h022), 1'b0);
    ld_write(1'b0, DAW'(2), DW'(12'h033), 1'b0);
    ld_write(1'b1, DAW'(5), DW'(12'hABC), 1'b0);
    for (int i = 0; i < DEPTH; i++) ld_write(1'b1, DAW'(BASE + i), DW'(i + 1), (i == DEPTH - 1));
    end_load();
    check("ins_ram0", ins_ram[0], 8'h11);
    check("ins_ram1", ins_ram[1], 8'h22);
    check("ins_ram2", ins_ram[2], 8'h33);
    check("data_ram5", data_ram[5], 12'hABC);

    // first run: dump 1,2,3,4 with ready high
    run_exec(3, 0, 1'b0);
    run_dump(0);

    // re-run from FINISH, done on the last watchdog cycle, ready toggling
    run_exec(TMO - 1, 4, 1'b1);
    run_dump(1);

    // load_req wins over startN
    enter_load(1'b1, 4);
    for (int i = 0; i < 6; i++)
      ld_write(1'($urandom_range(0, 1)), DAW'($urandom_range(0, 15)), DW'($urandom), (i == 5));
    end_load();

    // random runs
    for (int r = 0; r < 4; r++) begin
      run_exec($urandom_range(0, TMO - 1), (r == 0) ? 0 : 4, 1'b1);
      run_dump(2);
    end

    // watchdog expiry, sticky until reset
    run_timeout();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    exp_runs = 0;
    check("tout_rst_state", bus.state, 0);
    check("tout_rst_timeout", bus.timeout, 0);
    check("tout_rst_run_count", bus.run_count, 0);

    // reset while a word is valid in DUMP
    run_exec(1, 0, 1'b0);
    @(negedge clk);
    bus.dump_ready = 1'b0;
    #1;
    check("mid_dump_valid", bus.dump_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_state", bus.state, 0);
    check("mid_rst_valid", bus.dump_valid, 0);
    check("mid_rst_run_count", bus.run_count, 0);
    check("mid_rst_busy", bus.busy, 0);
    rst = 1'b0;

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL tb_time_limit: got=expired expected=finished");
    $fatal(1, "time limit");
  end

endmodule
